// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK cell bank controller.
// Opcodes, FSM states and the per-bit {j,k} encodings.
package jk_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,
    OP_CLEAR    = 3'd1,
    OP_SET      = 3'd2,
    OP_LOAD     = 3'd3,
    OP_TOGGLE   = 3'd4,
    OP_CLR_MASK = 3'd5,
    OP_SET_MASK = 3'd6,
    OP_ILLEGAL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] JK_HOLD  = 2'b00;
  localparam logic [1:0] JK_CLEAR = 2'b01;
  localparam logic [1:0] JK_SET   = 2'b10;
  localparam logic [1:0] JK_INV   = 2'b11;

endpackage

// File: rtl/jk_cell_bank.sv
// Bank of WIDTH master/slave JK cells: master_en applies JK to qm,
// slave_en copies qm to q. Ports: clk, res_n, j, k, master_en, slave_en, q.
module jk_cell_bank
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             master_en,
  input  logic             slave_en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] qm;
  logic [WIDTH-1:0] qm_nxt;

  always_comb begin
    qm_nxt = qm;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({j[i], k[i]})
        JK_HOLD:  qm_nxt[i] = qm[i];
        JK_CLEAR: qm_nxt[i] = 1'b0;
        JK_SET:   qm_nxt[i] = 1'b1;
        JK_INV:   qm_nxt[i] = ~qm[i];
        default:  qm_nxt[i] = qm[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      qm <= '0;
      q  <= '0;
    end else begin
      if (master_en) qm <= qm_nxt;
      if (slave_en)  q  <= qm;
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a JK cell bank: IDLE/APPLY/SETTLE/DONE.
// Ports: cmd_* handshake in, q/busy/done/err out; abort with JK_ABORT_EN.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
`ifdef JK_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state;
  state_e           state_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_nxt;
  logic             err_q;
  logic             hs;
  logic             stop;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = (state == ST_DONE);
  assign err       = done & err_q;
  assign hs        = cmd_valid & cmd_ready;

`ifdef JK_ABORT_EN
  logic abort_q;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      abort_q <= 1'b0;
    end else if (hs) begin
      abort_q <= 1'b0;
    end else if (state == ST_APPLY && abort) begin
      abort_q <= 1'b1;
    end
  end

  // Abort seen in APPLY or SETTLE ends the toggle loop.
  assign stop = abort_q | (abort & (state == ST_SETTLE));
`else
  assign stop = 1'b0;
`endif

  // Saturates at zero so the loop count never wraps.
  always_comb begin
    rem_nxt = rem_q;
    if (stop || rem_q == '0) rem_nxt = '0;
    else                     rem_nxt = rem_q - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (hs) begin
          if (cmd_op == OP_ILLEGAL) state_nxt = ST_DONE;
          else                      state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (op_q == OP_TOGGLE && rem_q != '0 && !stop)
          state_nxt = ST_APPLY;
        else
          state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_HOLD;
      data_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_q   <= op_e'(cmd_op);
        data_q <= cmd_data;
        rem_q  <= (cmd_op == OP_TOGGLE) ? cmd_count : '0;
        err_q  <= (cmd_op == OP_ILLEGAL);
      end else if (state == ST_SETTLE) begin
        rem_q <= rem_nxt;
      end
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    unique case (op_q)
      OP_HOLD:     ;
      OP_CLEAR:    k = '1;
      OP_SET:      j = '1;
      OP_LOAD: begin
        j = data_q;
        k = ~data_q;
      end
      OP_TOGGLE: begin
        j = data_q;
        k = data_q;
      end
      OP_CLR_MASK: k = data_q;
      OP_SET_MASK: j = data_q;
      OP_ILLEGAL:  ;
      default:     ;
    endcase
  end

  jk_cell_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk      (clk),
    .res_n    (res_n),
    .j        (j),
    .k        (k),
    .master_en(state == ST_APPLY),
    .slave_en (state == ST_SETTLE),
    .q        (q)
  );

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Randomized bench for jk_bank_ctrl against a command-level model.
// Define JK_ABORT_EN to also exercise the abort input.
module tb_jk_bank_ctrl;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic [3:0] cmd_count = '0;
`ifdef JK_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errs = 0;
  logic [7:0] mq = '0;

  always #5 clk = ~clk;

  jk_bank_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .res_n    (res_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_count(cmd_count),
`ifdef JK_ABORT_EN
    .abort    (abort),
`endif
    .q        (q),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] next_q(input logic [2:0] op,
                                        input logic [7:0] d,
                                        input logic [7:0] cur);
    case (op)
      3'd0:    return cur;
      3'd1:    return 8'h00;
      3'd2:    return 8'hFF;
      3'd3:    return d;
      3'd4:    return cur ^ d;
      3'd5:    return cur & ~d;
      3'd6:    return cur | d;
      default: return cur;
    endcase
  endfunction

  task automatic scramble();
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_data  = 8'($urandom);
    cmd_count = 4'($urandom);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] d,
                         input logic [3:0] c, input bit hold);
    int n;
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = c;
    @(posedge clk);
    #1;
    scramble();
    cmd_valid = hold;
    if (op == 3'd7) begin
      @(negedge clk);
      chk("ill_done", done, 1);
      chk("ill_err", err, 1);
      chk("ill_q", q, mq);
    end else begin
      n = (op == 3'd4) ? int'(c) + 1 : 1;
      for (int it = 0; it < n; it++) begin
        @(negedge clk);
        chk("apply_q", q, mq);
        chk("apply_busy", {busy, cmd_ready, done}, 3'b100);
        @(negedge clk);
        chk("settle_q", q, mq);
        chk("settle_busy", {busy, cmd_ready, done}, 3'b100);
        mq = next_q(op, d, mq);
      end
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("done_err", err, 0);
      chk("done_q", q, mq);
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int last;
    logic [7:0] qh;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done, err}, 0);
    res_n = 1'b1;

    run_cmd(3'd3, 8'hA5, 4'd0, 0);
    run_cmd(3'd4, 8'h0F, 4'd2, 1);
    chk("toggle_end", q, 8'hAA);
    run_cmd(3'd2, 8'h00, 4'd7, 0);
    chk("set_q", q, 8'hFF);
    run_cmd(3'd5, 8'h81, 4'd3, 0);
    chk("clrm_q", q, 8'h7E);
    run_cmd(3'd6, 8'h01, 4'd0, 1);
    chk("setm_q", q, 8'h7F);
    run_cmd(3'd0, 8'hFF, 4'd9, 0);
    chk("hold_q", q, 8'h7F);
    run_cmd(3'd7, 8'h00, 4'd0, 0);
    chk("ill_keep", q, 8'h7F);
    run_cmd(3'd4, 8'h01, 4'd15, 1);
    chk("tog16_q", q, 8'h7F);

    for (int r = 0; r < 40; r++) begin
      logic [2:0] op;
      logic [3:0] c;
      op = 3'($urandom_range(0, 7));
      c  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      run_cmd(op, 8'($urandom), c, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_data  = 8'($urandom) | 8'h01;
    cmd_count = 4'd5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    mq = '0;
    chk("mrst_q", q, 0);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_nodone", {done, busy}, 0);
      chk("mrst_qz", q, 0);
    end

    run_cmd(3'd3, 8'h3C, 4'd0, 0);
    qh = mq;
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_data  = 8'h55;
    cmd_count = 4'd3;
    acc  = 0;
    last = -4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        chk("b2b_gap", i - last, 4);
        last = i;
        acc++;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_count", acc, 5);
    repeat (2) @(negedge clk);
    chk("b2b_q", q, qh);

`ifdef JK_ABORT_EN
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_data  = 8'hFF;
    cmd_count = 4'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("ab_settle_q", q, mq);
    mq = ~mq;
    @(negedge clk);
    chk("ab_done", done, 1);
    chk("ab_err", err, 0);
    chk("ab_q", q, mq);
    @(negedge clk);
    chk("ab_idle", cmd_ready, 1);
    chk("ab_q_end", q, mq);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
